// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the DataMemory access controller.
// Holds the controller state encoding, word width and alignment mask.
package mem_ctrl_pkg;

    localparam int WORD_W = 32;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Saturating WAIT-cycle counter with clear, enable and terminal flag.
// Ports: clk, rst, clr, en in; tc out (high on the TIMEOUT-th counted cycle).
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The counter reaches TIMEOUT at the end of this cycle
    assign tc = en && (cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Requester-side controller holding a load/store on multi-cycle DataMemory.
// Ports: cpu_* pipeline side, address/mem_write/write_data/read_data/mem_ready memory side.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_DELAY = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [WORD_W-1:0] address,
    output logic              mem_write,
    output logic [WORD_W-1:0] write_data,
    input  logic [WORD_W-1:0] read_data,
    input  logic              mem_ready
);

    if (TIMEOUT <= MEM_DELAY + 1) begin : g_param_chk
        $error("TIMEOUT must exceed MEM_DELAY+1");
    end

    state_t state;
    logic   req;
    logic   bad;
    logic   tmo;

    assign req = cpu_read | cpu_write;
    assign bad = ((cpu_addr[1:0] & ALIGN_MASK) != 2'b00)
               | (cpu_read & cpu_write);

    assign cpu_stall = !rst &&
        ((state == IDLE && req) || state == SETUP || state == WAIT);

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state == SETUP),
        .en (state == WAIT),
        .tc (tmo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cpu_rdata  <= '0;
            cpu_done   <= 1'b0;
            cpu_err    <= 1'b0;
            address    <= '0;
            mem_write  <= 1'b0;
            write_data <= '0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        (req && bad): begin
                            state    <= RESP;
                            cpu_done <= 1'b1;
                            cpu_err  <= 1'b1;
                        end
                        (req && !bad): begin
                            address    <= cpu_addr;
                            write_data <= cpu_wdata;
                            mem_write  <= cpu_write;
                            state      <= SETUP;
                        end
                        default: ;
                    endcase
                end
                // DataMemory is restarting; mem_ready is stale here
                SETUP: state <= WAIT;
                WAIT: begin
                    if (mem_ready) begin
                        if (!mem_write) cpu_rdata <= read_data;
                        mem_write <= 1'b0;
                        state     <= RESP;
                        cpu_done  <= 1'b1;
                    end else if (tmo) begin
                        mem_write <= 1'b0;
                        state     <= RESP;
                        cpu_done  <= 1'b1;
                        cpu_err   <= 1'b1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
